// File: rtl/dot_matrix_driver.sv
// 8x8 LED dot-matrix scan driver with double-buffered frames and tear-free swap.
// Optional anti-ghost blanking on the last hold cycle of each row: DOT_GHOST_BLANK_EN.
module dot_matrix_driver #(
  parameter int unsigned ROW_HOLD = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] frame,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  dot_row,
  output logic [7:0]  dot_col,
  output logic        frame_sync
);

  localparam int unsigned HW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned FW = 64;
  localparam int unsigned DW = 8;

  logic          r_run;
  logic [RW-1:0] r_row;
  logic [HW-1:0] r_hold;
  logic [FW-1:0] r_display;
  logic [FW-1:0] r_pending;
  logic          r_ready;
  logic [DW-1:0] r_dot_row;
  logic [DW-1:0] r_dot_col;
  logic          r_frame_sync;

  logic          w_accept;
  logic          w_last_hold;
  logic          w_boundary;
  logic          w_swap;
  logic          w_blank;
  logic [RW-1:0] w_row_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [FW-1:0] w_display_nxt;

  assign w_accept    = frame_valid & r_ready;
  assign w_last_hold = r_run && (r_hold == HW'(ROW_HOLD - 1));
  assign w_boundary  = w_last_hold && (r_row == RW'(7));
  assign w_swap      = w_boundary && !r_ready;

  // Counters stay at (0,0) for the first edge after reset so row 0 gets its full hold.
  always_comb begin
    w_row_nxt     = r_row;
    w_hold_nxt    = r_hold;
    w_display_nxt = r_display;
    if (!r_run) begin
      w_row_nxt  = '0;
      w_hold_nxt = '0;
    end else if (w_last_hold) begin
      w_row_nxt  = r_row + RW'(1);
      w_hold_nxt = '0;
    end else begin
      w_hold_nxt = r_hold + HW'(1);
    end
    if (w_swap) begin
      w_display_nxt = r_pending;
    end
  end

`ifdef DOT_GHOST_BLANK_EN
  assign w_blank = (w_hold_nxt == HW'(ROW_HOLD - 1));
`else
  assign w_blank = 1'b0;
`endif

  // Outputs are registered from the next-cycle counter/display values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run        <= 1'b0;
      r_row        <= '0;
      r_hold       <= '0;
      r_display    <= '0;
      r_pending    <= '0;
      r_ready      <= 1'b1;
      r_dot_row    <= 8'hFF;
      r_dot_col    <= 8'h00;
      r_frame_sync <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_row     <= w_row_nxt;
      r_hold    <= w_hold_nxt;
      r_display <= w_display_nxt;
      if (w_swap) begin
        r_ready <= 1'b1;
      end else if (w_accept) begin
        r_pending <= frame;
        r_ready   <= 1'b0;
      end
      if (w_blank) begin
        r_dot_row <= 8'hFF;
        r_dot_col <= 8'h00;
      end else begin
        r_dot_row <= ~(DW'(1) << w_row_nxt);
        r_dot_col <= w_display_nxt[{w_row_nxt, 3'b000} +: DW];
      end
      r_frame_sync <= (w_row_nxt == '0) && (w_hold_nxt == '0);
    end
  end

  assign frame_ready = r_ready;
  assign dot_row     = r_dot_row;
  assign dot_col     = r_dot_col;
  assign frame_sync  = r_frame_sync;

endmodule

// File: tb/tb_dot_matrix_driver.sv
// Scoreboard bench for dot_matrix_driver: a per-cycle frame/row model pushes
// expected outputs; a monitor pops and compares every cycle.
module tb_dot_matrix_driver;

  localparam int RH  = 10;
  localparam int PER = 8 * RH;

  logic        clock;
  logic        reset;
  logic [63:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  dot_row;
  logic [7:0]  dot_col;
  logic        frame_sync;

  dot_matrix_driver #(.ROW_HOLD(RH)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .dot_row     (dot_row),
    .dot_col     (dot_col),
    .frame_sync  (frame_sync)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        sync;
    logic        ready;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model state: picture on screen, buffered picture, buffer occupancy.
  logic [63:0] m_disp;
  logic [63:0] m_pend;
  bit          m_full;
  int          cyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t expect_for(int t, logic [63:0] disp, bit full);
    exp_t e;
    int   row;
    int   h;
    row     = (t / RH) % 8;
    h       = t % RH;
    e.cyc   = 32'(t);
    e.row   = 8'hFF ^ (8'h01 << row);
    e.col   = disp[8*row +: 8];
    e.sync  = ((t % PER) == 0);
    e.ready = !full;
`ifdef DOT_GHOST_BLANK_EN
    if (h == RH - 1) begin
      e.row = 8'hFF;
      e.col = 8'h00;
    end
`else
    if (h < 0) e.row = 8'h00;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the model advances over the next edge and queues its prediction.
  task automatic step(input bit valid, input logic [63:0] data);
    @(negedge clock);
    cyc++;
    frame_valid = valid;
    frame       = data;
    if ((cyc % PER) == PER - 1 && m_full) begin
      m_disp = m_pend;
      m_full = 0;
    end else if (valid && !m_full) begin
      m_pend = data;
      m_full = 1;
    end
    q.push_back(expect_for(cyc + 1, m_disp, m_full));
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset       = 1'b1;
    frame_valid = 1'b0;
    m_disp      = '0;
    m_pend      = '0;
    m_full      = 0;
    cyc         = -1;
    q.delete();
    q.push_back(expect_for(0, m_disp, m_full));
    mon_en      = 1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row"},   32'(dot_row),     32'hFF);
    check({tag, "_col"},   32'(dot_col),     32'h00);
    check({tag, "_sync"},  32'(frame_sync),  32'h0);
    check({tag, "_ready"}, 32'(frame_ready), 32'h1);
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: no expectation at time %0t", $time);
      end else begin
        e = q.pop_front();
        if ({dot_row, dot_col, frame_sync, frame_ready} !== {e.row, e.col, e.sync, e.ready}) begin
          errors++;
          $display("FAIL cycle_%0d: got row=%h col=%h sync=%b ready=%b expected row=%h col=%h sync=%b ready=%b",
                   e.cyc, dot_row, dot_col, frame_sync, frame_ready, e.row, e.col, e.sync, e.ready);
        end
      end
    end
  end

  initial begin
    reset       = 1'b0;
    frame       = '0;
    frame_valid = 1'b0;
    m_disp      = '0;
    m_pend      = '0;
    m_full      = 0;
    cyc         = -1;
    #23;
    check_reset_values("por");

    // Idle scan with a blank picture.
    release_reset();
    repeat (2 * PER) step(0, '0);

    // Diagonal accepted mid-frame, then a rejected second frame while busy.
    while (((cyc + 1) % PER) != 30) step(0, '0);
    step(1, 64'h8040201008040201);
    repeat (10) step(0, '0);
    step(1, 64'hDEADBEEFCAFEF00D);
    repeat (3 * PER) step(0, '0);

    // Offer all-ones exactly on the boundary cycle.
    while (((cyc + 1) % PER) != PER - 1) step(0, '0);
    step(1, '1);
    repeat (3 * PER) step(0, '0);

    // Fill the pending buffer, then reset while row 4 is on screen.
    while (((cyc + 1) % PER) != 15) step(0, '0);
    step(1, 64'h0123456789ABCDEF);
    while (((cyc + 1) % PER) != 45) step(0, '0);
    step(0, '0);
    #2;
    mon_en = 0;
    reset  = 1'b0;
    #1;
    check_reset_values("mid_reset");
    q.delete();
    repeat (2) @(negedge clock);
    check_reset_values("held_reset");
    release_reset();
    repeat (PER + 20) step(0, '0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 7) == 0), {$urandom, $urandom});
    end

    @(posedge clock);
    #3;
    mon_en = 0;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
